// File: rtl/adder_tester_pkg.sv
// Shared types and constants for the adder tester: FSM states, LFSR taps,
// and the number of directed corner-case vectors issued before random ones.
package adder_tester_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam int          NUM_DIRECTED = 4;

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR; load and reset both take the seed.
module lfsr32
  import adder_tester_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n || load)
      q <= seed;
    else if (step)
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/adder_tester.sv
// Operand source and result checker for the lab adder: issues directed then
// LFSR vectors, compares the returned sum against a+b, counts and captures errors.
module adder_tester
  import adder_tester_pkg::*;
#(
  parameter int          N           = 32,
  parameter int          NUM_TESTS   = 256,
  parameter int          DUT_LATENCY = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2345
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  input  logic [N:0]   dut_sum,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  error_count,
  output logic [15:0]  tests_done,
  output logic [N-1:0] fail_a,
  output logic [N-1:0] fail_b
);

  localparam logic [15:0] LAST      = 16'(NUM_TESTS);
  localparam logic [15:0] FIRST_RND = 16'(NUM_DIRECTED);
  localparam logic [1:0]  DRAIN_END = 2'(DUT_LATENCY - 1);

  state_e       state;
  logic [15:0]  idx;        // index of the next vector to issue
  logic [1:0]   drain_cnt;
  logic [31:0]  lfsr_q;
  logic         start_ok, run_v, issue, step;
  logic [15:0]  issue_idx;
  logic [N-1:0] nxt_a, nxt_b;
  logic [N:0]   gold, cmp_gold;
  logic [N-1:0] cmp_a, cmp_b;
  logic         cmp_vld, mism;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign run_v    = (state == RUN);
  assign issue    = start_ok || (run_v && idx != LAST);
  assign step     = issue && !start_ok && (idx >= FIRST_RND);
  assign gold     = {1'b0, a} + {1'b0, b};
  assign mism     = cmp_vld && (dut_sum != cmp_gold);
  assign pass     = done && (error_count == 16'h0);

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (SEED),
    .step  (step),
    .q     (lfsr_q)
  );

  always_comb begin
    issue_idx = start_ok ? 16'h0 : idx;
    nxt_a     = '0;
    nxt_b     = '0;
    case (issue_idx)
      16'd0: begin nxt_a = '0; nxt_b = '0; end
      16'd1: begin nxt_a = '1; nxt_b = N'(1); end
      16'd2: begin nxt_a = '1; nxt_b = '1; end
      16'd3: begin nxt_a = {1'b1, {(N-1){1'b0}}}; nxt_b = {1'b1, {(N-1){1'b0}}}; end
      default: begin
        nxt_a = lfsr_q[N-1:0];
        for (int i = 0; i < N; i++) nxt_b[i] = lfsr_q[N-1-i];
      end
    endcase
  end

  // Expected sum and operands ride alongside the adder's own latency.
  generate
    if (DUT_LATENCY == 0) begin : g_lat0
      assign cmp_vld  = run_v;
      assign cmp_gold = gold;
      assign cmp_a    = a;
      assign cmp_b    = b;
    end else begin : g_latn
      logic [DUT_LATENCY-1:0]        vld_pipe;
      logic [DUT_LATENCY-1:0][N:0]   gold_pipe;
      logic [DUT_LATENCY-1:0][N-1:0] a_pipe, b_pipe;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[0] <= run_v;
          for (int i = 1; i < DUT_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        gold_pipe[0] <= gold;
        a_pipe[0]    <= a;
        b_pipe[0]    <= b;
        for (int i = 1; i < DUT_LATENCY; i++) begin
          gold_pipe[i] <= gold_pipe[i-1];
          a_pipe[i]    <= a_pipe[i-1];
          b_pipe[i]    <= b_pipe[i-1];
        end
      end

      assign cmp_vld  = vld_pipe[DUT_LATENCY-1];
      assign cmp_gold = gold_pipe[DUT_LATENCY-1];
      assign cmp_a    = a_pipe[DUT_LATENCY-1];
      assign cmp_b    = b_pipe[DUT_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      drain_cnt   <= '0;
      a           <= '0;
      b           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_count <= '0;
      tests_done  <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
    end else begin
      if (issue) begin
        a   <= nxt_a;
        b   <= nxt_b;
        idx <= issue_idx + 16'd1;
      end

      if (start_ok) begin
        error_count <= '0;
        tests_done  <= '0;
        fail_a      <= '0;
        fail_b      <= '0;
      end else if (cmp_vld) begin
        tests_done <= tests_done + 16'd1;
        if (mism) begin
          if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
          if (error_count == 16'h0) begin
            fail_a <= cmp_a;
            fail_b <= cmp_b;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (idx == LAST) begin
            drain_cnt <= '0;
            if (DUT_LATENCY == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tester.sv
// Bench for adder_tester: a fault-injecting zero-latency adder, and a two-stage
// registered adder checked at the matching and at a too-short latency.
module tb_adder_tester;

  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk, rst_n;
  logic start0, start1, start2;

  logic [31:0] a0, b0, fa0, fb0, a1, b1, fa1, fb1, a2, b2, fa2, fb2;
  logic [32:0] dut_sum0, dut_sum1, dut_sum2;
  logic [32:0] r1_1, r2_1, r1_2, r2_2;
  logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] ec0, td0, ec1, td1, ec2, td2;

  logic [15:0] inj_mask;
  bit          inj_stuck;
  int          cur_k;
  int          n_cmp, n_bad;

  adder_tester #(.N(32), .NUM_TESTS(16), .DUT_LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .dut_sum(dut_sum0),
    .busy(busy0), .done(done0), .pass(pass0), .error_count(ec0), .tests_done(td0),
    .fail_a(fa0), .fail_b(fb0));

  adder_tester #(.N(32), .NUM_TESTS(16), .DUT_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .dut_sum(dut_sum1),
    .busy(busy1), .done(done1), .pass(pass1), .error_count(ec1), .tests_done(td1),
    .fail_a(fa1), .fail_b(fb1));

  adder_tester #(.N(32), .NUM_TESTS(16), .DUT_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .dut_sum(dut_sum2),
    .busy(busy2), .done(done2), .pass(pass2), .error_count(ec2), .tests_done(td2),
    .fail_a(fa2), .fail_b(fb2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-latency adder with optional +1 corruption on chosen vectors, or stuck at 0.
  always_comb begin
    dut_sum0 = {1'b0, a0} + {1'b0, b0};
    if (inj_stuck) dut_sum0 = '0;
    else if (cur_k >= 0 && cur_k < 16 && inj_mask[cur_k[3:0]]) dut_sum0 = dut_sum0 + 33'd1;
  end

  // Two-stage registered adders.
  always @(posedge clk) begin
    r1_1 <= {1'b0, a1} + {1'b0, b1};  r2_1 <= r1_1;
    r1_2 <= {1'b0, a2} + {1'b0, b2};  r2_2 <= r1_2;
  end
  assign dut_sum1 = r2_1;
  assign dut_sum2 = r2_2;

  // Reference vector k: directed corners, then LFSR state stepped k-4 times.
  function automatic logic [63:0] ref_vec(input int k);
    logic [31:0] s, r;
    case (k)
      0: return 64'h0;
      1: return {32'hFFFF_FFFF, 32'h1};
      2: return {32'hFFFF_FFFF, 32'hFFFF_FFFF};
      3: return {32'h8000_0000, 32'h8000_0000};
      default: begin
        s = SEED;
        for (int i = 4; i < k; i++) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
        for (int i = 0; i < 32; i++) r[i] = s[31-i];
        return {s, r};
      end
    endcase
  endfunction

  // Expected outcome of a 16-vector run from the set of corrupted vectors.
  task automatic model_run(input logic [15:0] mask, input bit stuck,
                           output logic [15:0] err, output logic [31:0] fa, output logic [31:0] fb);
    logic [63:0] v;
    bit bad;
    err = 0; fa = 0; fb = 0;
    for (int k = 0; k < 16; k++) begin
      v   = ref_vec(k);
      bad = stuck ? ((33'(v[63:32]) + 33'(v[31:0])) != 33'd0) : mask[k];
      if (bad) begin
        if (err == 0) begin fa = v[63:32]; fb = v[31:0]; end
        err++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One run of u0: pulse start, track presented vector, check a/b each cycle.
  task automatic run0(input string nm, input logic [15:0] mask, input bit stuck, output int dcyc);
    int vbad;
    inj_mask = mask; inj_stuck = stuck;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    dcyc = -1; vbad = 0;
    for (int c = 1; c <= 40; c++) begin
      cur_k = c - 1;
      if (done0) begin dcyc = c; break; end
      if (c <= 16 && {a0, b0} !== ref_vec(c - 1)) vbad++;
      @(posedge clk); #1;
    end
    chk({nm, " operand sequence errors"}, 64'(vbad), 64'd0);
  endtask

  typedef struct {
    logic [15:0] mask;
    bit          stuck;
    logic [15:0] err;
    logic [31:0] fa, fb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int dcyc, d1, d2;
    logic [15:0] e;
    logic [31:0] fa, fb;
    n_cmp = 0; n_bad = 0; cur_k = -1;
    inj_mask = 0; inj_stuck = 0;
    start0 = 0; start1 = 0; start2 = 0;
    rst_n = 0;

    tbl[0] = '{16'h0000, 1'b0, 16'd0,  32'h0,         32'h0};
    tbl[1] = '{16'h0004, 1'b0, 16'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[2] = '{16'h0000, 1'b1, 16'd15, 32'hFFFF_FFFF, 32'h1};
    model_run(16'h0220, 1'b0, e, fa, fb);
    tbl[3] = '{16'h0220, 1'b0, e, fa, fb};
    for (int i = 4; i < 7; i++) begin
      tbl[i].mask  = 16'($urandom);
      tbl[i].stuck = 1'b0;
      model_run(tbl[i].mask, 1'b0, tbl[i].err, tbl[i].fa, tbl[i].fb);
    end

    repeat (2) @(posedge clk); #1;
    chk("reset operands", {a0, b0}, 64'h0);
    chk("reset status", {61'h0, busy0, done0, pass0}, 64'h0);
    chk("reset counters", {ec0, td0}, 64'h0);
    chk("reset fail capture", {fa0, fb0}, 64'h0);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run0($sformatf("run%0d", i), tbl[i].mask, tbl[i].stuck, dcyc);
      chk($sformatf("run%0d done cycle", i), 64'(dcyc), 64'd17);
      chk($sformatf("run%0d busy at done", i), 64'(busy0), 64'd0);
      chk($sformatf("run%0d tests_done", i), 64'(td0), 64'd16);
      chk($sformatf("run%0d error_count", i), 64'(ec0), 64'(tbl[i].err));
      chk($sformatf("run%0d fail pair", i), {fa0, fb0}, {tbl[i].fa, tbl[i].fb});
      chk($sformatf("run%0d pass", i), 64'(pass0), 64'(tbl[i].err == 0));
      repeat (2) @(posedge clk); #1;
      chk($sformatf("run%0d done held", i), 64'(done0), 64'd1);
    end
    inj_mask = 0; inj_stuck = 0;

    // Registered adder at matching latency (2) and at too-short latency (1).
    start1 = 1; start2 = 1;
    @(posedge clk); #1;
    start1 = 0; start2 = 0;
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done1 && d1 < 0) d1 = c;
      if (done2 && d2 < 0) d2 = c;
      @(posedge clk); #1;
    end
    chk("lat2 done cycle", 64'(d2), 64'd19);
    chk("lat2 pass", 64'(pass2), 64'd1);
    chk("lat2 tests_done", 64'(td2), 64'd16);
    chk("lat1 done cycle", 64'(d1), 64'd18);
    chk("lat1 error_count>=14", 64'(ec1 >= 16'd14), 64'd1);

    // Mid-run reset with errors accumulated, then a clean replay.
    inj_stuck = 1;
    start0 = 1;
    @(posedge clk); #1;
    start0 = 0;
    repeat (5) @(posedge clk); #1;
    chk("midrun operands vec5", {a0, b0}, ref_vec(5));
    chk("midrun error_count", 64'(ec0), 64'd4);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("midrun reset operands", {a0, b0}, 64'h0);
    chk("midrun reset status", {61'h0, busy0, done0, pass0}, 64'h0);
    chk("midrun reset counters", {ec0, td0}, 64'h0);
    chk("midrun reset fail capture", {fa0, fb0}, 64'h0);
    inj_stuck = 0;
    @(posedge clk); #1;
    run0("replay", 16'h0, 1'b0, dcyc);
    chk("replay done cycle", 64'(dcyc), 64'd17);
    chk("replay pass", 64'(pass0), 64'd1);

    // start held high: no restart while busy, back-to-back identical runs.
    d1 = -1; d2 = -1; e = 0;
    start0 = 1;
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (c <= 16 && {a0, b0} !== ref_vec(c - 1)) e++;
      if (c >= 18 && c <= 33 && {a0, b0} !== ref_vec(c - 18)) e++;
      if (c == 18) chk("held start restart busy", 64'(busy0), 64'd1);
      if (done0 && d1 < 0) d1 = c;
      else if (done0 && d1 >= 0 && c > d1 + 1) begin d2 = c; start0 = 0; break; end
      @(posedge clk); #1;
    end
    start0 = 0;
    chk("held start operand errors", 64'(e), 64'd0);
    chk("held start first done", 64'(d1), 64'd17);
    chk("held start second done", 64'(d2), 64'd34);
    chk("held start second pass", {47'h0, pass0, td0}, {47'h0, 1'b1, 16'd16});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
